// File: rtl/lc3b_types.sv
// Shared LC-3b types: data-cache controller state encoding and perf counter width.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } lc3b_dcache_state;

  localparam int DCACHE_PERF_CNT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Clear beats increment; the count sticks at all-ones once reached.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != {width{1'b1}})) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/d_cache_control.sv
// Controller FSM for the 2-way write-back data cache: hit path, victim writeback, line allocate.
// Optional saturating perf counters are built only when D_CACHE_PERF_CNT_EN is defined.
module d_cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = DCACHE_PERF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 pmem_resp,
  input  logic                 perf_clr,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 writemux_sel,
  output logic                 datamux_sel,
  output logic                 lru_write,
  output logic                 write_back,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  lc3b_dcache_state state, next_state;
  logic             request;

  assign request = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Hit acknowledgement is gated by rst_n so a reset cycle never completes a request.
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    writemux_sel = 1'b0;
    datamux_sel  = 1'b0;
    lru_write    = 1'b0;
    write_back   = 1'b0;
    case (state)
      IDLE: begin
        if (request && rst_n) begin
          if (hit) begin
            mem_resp  = 1'b1;
            lru_write = 1'b1;
          end else if (dirty) begin
            next_state = WRITEBACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        write_back = 1'b1;
        if (pmem_resp) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        datamux_sel  = 1'b1;
        writemux_sel = 1'b1;
        if (pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));
`endif

`ifdef D_CACHE_PERF_CNT_EN
  logic miss_inc, wb_inc;

  assign miss_inc = (state == IDLE) && (next_state != IDLE);
  assign wb_inc   = (state == WRITEBACK) && pmem_resp;

  sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(mem_resp), .count(hit_count)
  );
  sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(miss_inc), .count(miss_count)
  );
  sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst_n(rst_n), .clr(perf_clr), .inc(wb_inc), .count(wb_count)
  );
`else
  logic unused_perf_clr;

  assign unused_perf_clr = perf_clr;
  assign hit_count       = '0;
  assign miss_count      = '0;
  assign wb_count        = '0;
`endif

endmodule

// File: tb/tb_d_cache_control.sv
// Directed testbench for d_cache_control; counter expectations follow D_CACHE_PERF_CNT_EN.
module tb_d_cache_control;

`ifdef D_CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int W = 4;
  // Control vector order: {mem_resp, pmem_read, pmem_write, writemux_sel, datamux_sel, lru_write, write_back}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_HIT   = 7'b1000010;
  localparam logic [6:0] C_WB    = 7'b0010001;
  localparam logic [6:0] C_ALLOC = 7'b0101100;

  logic clk, rst_n, mem_read, mem_write, hit, dirty, pmem_resp, perf_clr;
  logic mem_resp, pmem_read, pmem_write, writemux_sel, datamux_sel, lru_write, write_back;
  logic [W-1:0] hit_count, miss_count, wb_count;
  logic [6:0] ctl;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] e_hit, e_miss, e_wb;

  assign ctl = {mem_resp, pmem_read, pmem_write, writemux_sel, datamux_sel, lru_write, write_back};

  d_cache_control #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .perf_clr(perf_clr),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .writemux_sel(writemux_sel), .datamux_sel(datamux_sel), .lru_write(lru_write),
    .write_back(write_back), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  function automatic logic [3*W-1:0] exp_cnts();
    return PERF ? {e_hit, e_miss, e_wb} : '0;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic drive(input logic rd, input logic wr, input logic h, input logic d, input logic pr);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    hit       = h;
    dirty     = d;
    pmem_resp = pr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; perf_clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    e_hit = '0; e_miss = '0; e_wb = '0;
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, C_NONE);
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL reset_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_hit();
    drive(1, 0, 1, 0, 0);
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL read_hit_ctl: got %b expected %b", ctl, C_HIT);
    end
    e_hit = sat_inc(e_hit);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL idle_ctl: got %b expected %b", ctl, C_NONE);
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL read_hit_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
  endtask

  task automatic test_idle_pmem_resp();
    drive(0, 0, 0, 0, 1);
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL idle_pmem_resp_ctl: got %b expected %b", ctl, C_NONE);
    end
    drive(0, 1, 1, 0, 0);
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL idle_after_resp_hit: got %b expected %b", ctl, C_HIT);
    end
    e_hit = sat_inc(e_hit);
  endtask

  task automatic test_clean_read_miss();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL clean_miss_lookup: got %b expected %b", ctl, C_NONE);
    end
    e_miss = sat_inc(e_miss);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 0, 0, (i == 6) ? 1'b1 : 1'b0);
      checks++;
      if (ctl !== C_ALLOC) begin
        fails++; $display("[TB] FAIL clean_miss_alloc_c%0d: got %b expected %b", i, ctl, C_ALLOC);
      end
    end
    drive(1, 0, 1, 0, 0);
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL clean_miss_resp: got %b expected %b", ctl, C_HIT);
    end
    e_hit = sat_inc(e_hit);
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL clean_miss_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
  endtask

  task automatic test_dirty_write_miss();
    drive(0, 1, 0, 1, 0);
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL dirty_miss_lookup: got %b expected %b", ctl, C_NONE);
    end
    e_miss = sat_inc(e_miss);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 1, (i == 4) ? 1'b1 : 1'b0);
      checks++;
      if (ctl !== C_WB) begin
        fails++; $display("[TB] FAIL dirty_miss_wb_c%0d: got %b expected %b", i, ctl, C_WB);
      end
    end
    e_wb = sat_inc(e_wb);
    for (int i = 1; i <= 2; i++) begin
      drive(0, 1, 0, 0, (i == 2) ? 1'b1 : 1'b0);
      checks++;
      if (ctl !== C_ALLOC) begin
        fails++; $display("[TB] FAIL dirty_miss_alloc_c%0d: got %b expected %b", i, ctl, C_ALLOC);
      end
    end
    drive(0, 1, 1, 0, 0);
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL dirty_miss_resp: got %b expected %b", ctl, C_HIT);
    end
    e_hit = sat_inc(e_hit);
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL dirty_miss_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
  endtask

  task automatic test_reset_mid_writeback();
    drive(1, 0, 0, 1, 0);
    e_miss = sat_inc(e_miss);
    drive(1, 0, 0, 1, 0);
    checks++;
    if (ctl !== C_WB) begin
      fails++; $display("[TB] FAIL rst_wb_c1: got %b expected %b", ctl, C_WB);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== C_WB) begin
      fails++; $display("[TB] FAIL rst_wb_c2_moore: got %b expected %b", ctl, C_WB);
    end
    e_hit = '0; e_miss = '0; e_wb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_read = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      fails++; $display("[TB] FAIL rst_wb_after: got %b expected %b", ctl, C_NONE);
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL rst_wb_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
  endtask

  task automatic test_dropped_request();
    drive(1, 0, 0, 0, 0);
    e_miss = sat_inc(e_miss);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_ALLOC) begin
      fails++; $display("[TB] FAIL drop_alloc_c1: got %b expected %b", ctl, C_ALLOC);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (ctl !== C_ALLOC) begin
      fails++; $display("[TB] FAIL drop_alloc_c2: got %b expected %b", ctl, C_ALLOC);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(0, 0, 1, 0, 0);
      checks++;
      if (ctl !== C_NONE) begin
        fails++; $display("[TB] FAIL drop_no_resp_c%0d: got %b expected %b", i, ctl, C_NONE);
      end
    end
    drive(1, 0, 1, 0, 0);
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL drop_back_idle: got %b expected %b", ctl, C_HIT);
    end
    e_hit = sat_inc(e_hit);
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 1, 0, 0);
      checks++;
      if (ctl !== C_HIT) begin
        fails++; $display("[TB] FAIL sat_hit_c%0d: got %b expected %b", i, ctl, C_HIT);
      end
      e_hit = sat_inc(e_hit);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL sat_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
    @(negedge clk);
    perf_clr = 1'b1;
    mem_read = 1'b1;
    hit      = 1'b1;
    #1;
    checks++;
    if (ctl !== C_HIT) begin
      fails++; $display("[TB] FAIL clr_hit_ctl: got %b expected %b", ctl, C_HIT);
    end
    e_hit = '0; e_miss = '0; e_wb = '0;
    @(negedge clk);
    perf_clr = 1'b0;
    mem_read = 1'b0;
    hit      = 1'b0;
    #1;
    checks++;
    if ({hit_count, miss_count, wb_count} !== exp_cnts()) begin
      fails++; $display("[TB] FAIL clr_counts: got %h expected %h", {hit_count, miss_count, wb_count}, exp_cnts());
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
    dirty = 1'b0; pmem_resp = 1'b0; perf_clr = 1'b0;
    e_hit = '0; e_miss = '0; e_wb = '0;
    $display("[TB] d_cache_control bench, perf counters %0s", PERF ? "on" : "off");
    test_reset();
    test_read_hit();
    test_idle_pmem_resp();
    test_clean_read_miss();
    test_dirty_write_miss();
    test_reset_mid_writeback();
    test_dropped_request();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/d_cache_control.md
Name: d_cache_control

Overview:
- FSM controller that sequences the 2-way set-associative write-back data cache datapath.
- Sits between the CPU memory port and physical memory.
- Decodes hit/dirty status from the datapath, drives its mux/write/LRU controls, and runs the pmem handshake for victim writeback and line allocate.
- Single-cycle hit; misses serviced as optional WRITEBACK, then ALLOCATE, then re-lookup.

Parameters:
CNT_WIDTH, 16, width of each optional performance counter (saturating)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
hit  input  1  datapath: addressed line valid in either way
dirty  input  1  datapath: victim (LRU) way dirty
pmem_resp  input  1  physical memory completion pulse
perf_clr  input  1  synchronous clear of perf counters (ignored without macro)
mem_resp  output  1  CPU completion pulse
pmem_read  output  1  physical line read request
pmem_write  output  1  physical line write request
writemux_sel  output  1  1 = way line-load enable (fill from pmem)
datamux_sel  output  1  1 = way data source is pmem_rdata; 0 = CPU write merge
lru_write  output  1  update LRU array (datapath qualifies with hit)
write_back  output  1  1 = pmem_address is victim tag/set; blocks victim dirty-bit load
hit_count  output  CNT_WIDTH  completed hit accesses (0 without macro)
miss_count  output  CNT_WIDTH  miss entries (0 without macro)
wb_count  output  CNT_WIDTH  victim writebacks (0 without macro)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; all outputs 0 from that edge; counters=0.
- Reset mid-operation aborts immediately with no mem_resp. pmem_read/pmem_write drop the following cycle; the pmem side tolerates the abandoned request.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Request (mem_read|mem_write) with hit=1: mem_resp=1, lru_write=1 combinationally in the same cycle. mem_write additionally commits the byte-masked merge (datamux_sel=0). Stay in IDLE.
  - Request with hit=0, dirty=1: go to WRITEBACK.
  - Request with hit=0, dirty=0: go to ALLOCATE.
  - No request: all controls 0.
- WRITEBACK:
  - Outputs: pmem_write=1, write_back=1; all other outputs 0.
  - On pmem_resp: go to ALLOCATE. Otherwise hold.
- ALLOCATE:
  - Outputs: pmem_read=1, datamux_sel=1, writemux_sel=1, write_back=0.
  - The way loads pmem_rdata, tag, valid, and clean dirty on the pmem_resp cycle.
  - On pmem_resp: go to IDLE. The held request then hits the next cycle, so a miss costs its pmem latencies plus one lookup cycle.
- pmem_read/pmem_write are Moore outputs (state only). They stay high until pmem_resp, then drop on the next edge. They are never high together.
- mem_resp is at most 1 cycle per request and is never asserted outside IDLE.
- mem_read and mem_write both high is illegal. The write path takes priority; a simulation-only assertion flags it.
- Request dropped mid-miss: WRITEBACK/ALLOCATE still complete to IDLE (line installed), and no mem_resp is issued.
- pmem_resp in IDLE is ignored.

Optional Feature:
- Macro: D_CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on each mem_resp.
  - miss_count increments on each IDLE→WRITEBACK/ALLOCATE transition.
  - wb_count increments on WRITEBACK exit.
  - All counters saturate at 2^CNT_WIDTH-1.
  - perf_clr zeroes all counters; it wins over a simultaneous increment.
- Undefined: counter ports driven constant 0; perf_clr unused; no counter flops.

Decomposition:
- lc3b_types gains typedef enum lc3b_dcache_state {IDLE, WRITEBACK, ALLOCATE}.
- lc3b_types gains constant DCACHE_PERF_CNT_WIDTH = 16 (default for CNT_WIDTH).
- One sub-module: sat_counter (parameter width; inputs clk, rst_n, clr, inc; output count). It is instantiated three times under the macro.

Test Plan:
- Read hit: hit=1, mem_read=1 in IDLE → mem_resp=1 and lru_write=1 same cycle, pmem_read=0; hit_count 0→1.
- Clean read miss: hit=0, dirty=0 → ALLOCATE next cycle with pmem_read=1, datamux_sel=1, writemux_sel=1. Bench holds hit=0 and pmem_resp=0 for 5 cycles, then pulses pmem_resp at cycle 6 with hit=1 the following cycle → IDLE, mem_resp 1 cycle after pmem_resp, pmem_write never 1.
- Dirty write miss: hit=0, dirty=1, mem_write=1 → pmem_write=1, write_back=1 until pmem_resp (4 cycles), then pmem_read=1, write_back=0, then mem_resp. wb_count=1, miss_count=1.
- Reset mid-WRITEBACK: rst_n=0 for 1 cycle at WRITEBACK cycle 2 → next cycle state IDLE, pmem_write=0, mem_resp=0, counters 0.
- Dropped request: mem_read deasserted during ALLOCATE → pmem_resp returns FSM to IDLE, no mem_resp ever issued.
- Saturation (CNT_WIDTH=4, macro on): 20 consecutive hits → hit_count=15; perf_clr with hit same cycle → 0.
